// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table: geometry, entry field
// layout and the write-scheduler state encoding.
package bht_pkg;

  localparam int BHT_IDX_W  = 6;
  localparam int BHT_DATA_W = 22;

  // Entry layout: {valid, tag[7:0], target[10:0], ctr[1:0]}
  localparam int VALID_BIT = 21;
  localparam int TAG_MSB   = 20;
  localparam int TAG_LSB   = 13;
  localparam int TGT_MSB   = 12;
  localparam int TGT_LSB   = 2;
  localparam int CTR_MSB   = 1;
  localparam int CTR_LSB   = 0;

  // SWEEP clears the table one entry per enabled cycle; RUN serves requests.
  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } bht_state_e;

endpackage

// File: rtl/bht_upd_fifo.sv
// Deferred-update FIFO. Each slot carries a kill flag so an allocation can
// cancel queued updates to the same index without disturbing queue order;
// killed slots still occupy space and are consumed by a normal pop.
module bht_upd_fifo #(
  parameter int IDX_W  = 6,
  parameter int DATA_W = 22,
  parameter int QDEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       nrst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [IDX_W-1:0]           push_idx,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       push_kill,
  input  logic                       pop,
  input  logic                       kill_en,
  input  logic [IDX_W-1:0]           kill_idx,
  output logic                       head_kill,
  output logic [IDX_W-1:0]           head_idx,
  output logic [DATA_W-1:0]          head_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(QDEPTH):0]    count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              kill_reg [QDEPTH];
  logic [IDX_W-1:0]  idx_reg  [QDEPTH];
  logic [DATA_W-1:0] data_reg [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  assign head_kill = kill_reg[rd_ptr_reg];
  assign head_idx  = idx_reg[rd_ptr_reg];
  assign head_data = data_reg[rd_ptr_reg];
  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(QDEPTH));
  assign count     = count_reg;

  // Per-slot storage: a push loads the slot; otherwise a matching allocation
  // marks it killed. A simultaneous push and pop on a full queue reuses the
  // head slot, which is safe because the head is read before the edge.
  genvar gi;
  generate
    for (gi = 0; gi < QDEPTH; gi++) begin : g_slot
      // Slot contents and kill flag
      always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
          kill_reg[gi] <= 1'b0;
          idx_reg[gi]  <= '0;
          data_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          kill_reg[gi] <= push_kill;
          idx_reg[gi]  <= push_idx;
          data_reg[gi] <= push_data;
        end else if (kill_en && (idx_reg[gi] == kill_idx)) begin
          kill_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Pointers and occupancy; clear wins over any push/pop in the same cycle
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/bht_write_scheduler.sv
// Single write port arbiter for the branch history table. Allocations always
// win the port; counter updates are written directly when nothing is queued,
// otherwise deferred in order. Also runs the clear sweep after reset or an
// invalidate request.
module bht_write_scheduler
  import bht_pkg::*;
#(
  parameter int IDX_W  = BHT_IDX_W,
  parameter int DATA_W = BHT_DATA_W,
  parameter int QDEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     nrst,
  input  logic                     en,
  input  logic                     stall,
  input  logic                     inv_req,
  input  logic                     alloc_req,
  input  logic [IDX_W-1:0]         alloc_idx,
  input  logic [DATA_W-1:0]        alloc_data,
  output logic                     alloc_ack,
  input  logic                     upd_req,
  input  logic [IDX_W-1:0]         upd_idx,
  input  logic [DATA_W-1:0]        upd_data,
  output logic                     upd_ack,
  output logic                     wr_en,
  output logic [IDX_W-1:0]         wr_idx,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  bht_state_e        state_reg;
  logic [IDX_W-1:0]  sweep_ptr_reg;
  logic              wr_en_reg;
  logic [IDX_W-1:0]  wr_idx_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              busy_reg;

  logic              fifo_clr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_push_kill;
  logic              head_kill;
  logic [IDX_W-1:0]  head_idx;
  logic [DATA_W-1:0] head_data;
  logic              fifo_empty;
  logic              fifo_full;

  logic run_active;
  logic inv_take;
  logic alloc_take;
  logic bypass_take;

  // Request classification for the current cycle; only one table write may
  // be produced, with invalidate > allocation > queued update > bypass.
  always_comb begin
    run_active  = nrst && en && (state_reg == RUN) && !stall;
    inv_take    = run_active && inv_req;
    alloc_take  = run_active && !inv_req && alloc_req;
    fifo_pop    = run_active && !inv_req && !alloc_req && !fifo_empty;
    bypass_take = run_active && !inv_req && !alloc_req && fifo_empty && upd_req;
    alloc_ack   = alloc_take;
    // Beside an allocation an update needs a free slot; otherwise it is
    // either bypassed or queued behind a pop that frees room this cycle.
    upd_ack     = run_active && !inv_req && upd_req && (!alloc_req || !fifo_full);
    fifo_push   = upd_ack && !bypass_take;
    fifo_clr    = inv_take;
    fifo_push_kill = alloc_take && (upd_idx == alloc_idx);
  end

  bht_upd_fifo #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .nrst      (nrst),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .push_idx  (upd_idx),
    .push_data (upd_data),
    .push_kill (fifo_push_kill),
    .pop       (fifo_pop),
    .kill_en   (alloc_take),
    .kill_idx  (alloc_idx),
    .head_kill (head_kill),
    .head_idx  (head_idx),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (q_count)
  );

  // FSM, sweep pointer and the registered table write port
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= SWEEP;
      sweep_ptr_reg <= '0;
      wr_en_reg     <= 1'b0;
      wr_idx_reg    <= '0;
      wr_data_reg   <= '0;
      busy_reg      <= 1'b1;
    end else begin
      wr_en_reg <= 1'b0;
      if (en) begin
        case (state_reg)
          SWEEP: begin
            if (inv_req) begin
              sweep_ptr_reg <= '0;
            end else begin
              wr_en_reg     <= 1'b1;
              wr_idx_reg    <= sweep_ptr_reg;
              wr_data_reg   <= '0;
              sweep_ptr_reg <= sweep_ptr_reg + 1'b1;
              if (sweep_ptr_reg == LAST_IDX) begin
                state_reg <= RUN;
                busy_reg  <= 1'b0;
              end
            end
          end
          RUN: begin
            if (!stall) begin
              if (inv_take) begin
                state_reg     <= SWEEP;
                sweep_ptr_reg <= '0;
                busy_reg      <= 1'b1;
              end else if (alloc_take) begin
                wr_en_reg   <= 1'b1;
                wr_idx_reg  <= alloc_idx;
                wr_data_reg <= alloc_data;
              end else if (fifo_pop) begin
                // A killed head is retired without touching the table
                if (!head_kill) begin
                  wr_en_reg   <= 1'b1;
                  wr_idx_reg  <= head_idx;
                  wr_data_reg <= head_data;
                end
              end else if (bypass_take) begin
                wr_en_reg   <= 1'b1;
                wr_idx_reg  <= upd_idx;
                wr_data_reg <= upd_data;
              end
            end
          end
          default: state_reg <= SWEEP;
        endcase
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_idx  = wr_idx_reg;
  assign wr_data = wr_data_reg;
  assign busy    = busy_reg;

endmodule
